axis_matvec_fx: RTL and testbench
=================================

// Module: axis_matvec_fx
// PURPOSE
//  Parametrised AXI4-Stream matrix-vector engine, successor to the fixed 20x10 dot block.
//  Accepts an N_IN-element input vector and emits N_OUT dot products y[r] = sum_c W[r][c]*x[c].
//  Unlike its predecessor, the weights are not baked in: they are loaded at runtime over the same input stream.
//  Arithmetic is signed fixed point, one MAC per cycle.
// PARAMETERS
//  N_IN    20  input vector length (columns)
//  N_OUT   10  output vector length (rows)
//  DATA_W  16  signed sample/weight/result width (two's complement)
//  FRAC_W   8  fractional bits of the Qx.FRAC_W format (1.0 = 1<<FRAC_W)
//  ACC_W   2*DATA_W+$clog2(N_IN)  accumulator width; must never overflow
// PORTS
//  aclk                in   1       clock, all logic on rising edge
//  aresetn             in   1       asynchronous active-low reset
//  INPUT_AXIS_TDATA    in   DATA_W  weight or vector element
//  INPUT_AXIS_TUSER    in   1       frame type, sampled on the first beat only: 1 = weights, 0 = vector
//  INPUT_AXIS_TLAST    in   1       last beat of frame
//  INPUT_AXIS_TVALID   in   1       input valid
//  INPUT_AXIS_TREADY   out  1       input ready
//  OUTPUT_AXIS_TDATA   out  DATA_W  result y[r], r = 0..N_OUT-1 in order
//  OUTPUT_AXIS_TLAST   out  1       high with y[N_OUT-1]
//  OUTPUT_AXIS_TVALID  out  1       output valid
//  OUTPUT_AXIS_TREADY  in   1       output ready
//  FRAME_ERR           out  1       sticky: input frame length mismatch seen
// BEHAVIOUR
//  Reset (async, aresetn=0): all outputs 0 (TREADY, TVALID, TLAST, TDATA, FRAME_ERR).
//   Also cleared: W (all 0), x buffer (all 0), state=IDLE. First edge after release: TREADY=1.
//  FSM: IDLE -> LOAD_W | LOAD_X on first accepted beat (per TUSER); LOAD_W -> IDLE on TLAST;
//   LOAD_X -> COMPUTE on TLAST; COMPUTE -> SEND after N_IN MACs; SEND -> COMPUTE (next row)
//   on handshake, or -> IDLE after row N_OUT-1 handshakes.
//  The first beat of a frame is itself stored as element 0.
//  TREADY=1 in IDLE/LOAD_W/LOAD_X, 0 in COMPUTE/SEND. A beat transfers on TVALID&&TREADY.
//  Weight frame: N_IN*N_OUT beats, row-major (beat k -> W[k/N_IN][k%N_IN]).
//   Weights persist across vectors until reloaded or reset.
//  Vector frame: N_IN beats -> x[0..N_IN-1].
//  Short frame (TLAST early): unwritten entries of that frame are set to 0; FRAME_ERR<=1.
//  Long frame: beats past the expected count are accepted and discarded until TLAST; FRAME_ERR<=1.
//  FRAME_ERR clears only on reset.
//  COMPUTE: acc cleared at row start; acc += sext(W[r][c])*sext(x[c]), c = 0..N_IN-1, one per cycle.
//  Result: floor(acc / 2^FRAC_W) via arithmetic shift, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  Latency: the last input beat is accepted at edge E; the first OUTPUT_AXIS_TVALID is visible after edge E+N_IN+1.
//   Each later row: N_IN+1 cycles after the prior output handshake.
//  SEND: TVALID held, TDATA/TLAST stable until TREADY. TVALID drops the cycle after the final handshake.
//  Reset mid-operation: immediate return to reset state; a partially loaded frame is discarded.
//  Upstream must re-send weights after reset.
// TESTING
//  1 identity: W[r][c]=0x0100 if r==c else 0, x[c]=c<<8 -> outputs 0x0000,0x0100..0x0900.
//    TLAST on the 10th output only; FRAME_ERR=0.
//  2 saturation: all W=0x7FFF, x=0x7FFF -> ten outputs 0x7FFF.
//    All W=0x7FFF, x=0x8000 -> ten outputs 0x8000.
//  3 rounding: W[0][0]=0xFF00 (-1.0), rest 0; x[0]=0x0001 -> y[0]=0xFFFF (floor), y[1..9]=0.
//  4 backpressure: case 1 with OUTPUT_AXIS_TREADY toggling each cycle -> identical data.
//    TDATA/TLAST stable while TVALID&&!TREADY; INPUT_AXIS_TREADY=0 throughout COMPUTE/SEND.
//  5 frame errors: vector frame with TLAST on beat 5 -> FRAME_ERR=1, x[5..19] treated as 0.
//    With case-1 weights: y = 0,0x100..0x400, then 0.
//  6 latency/reset: last input beat accepted at edge E -> first TVALID after edge E+21.
//    Drop aresetn after the 3rd output -> TVALID=0 at once. A new vector frame then yields ten 0x0000 (weights cleared).

Source files
------------

// File: rtl/axis_matvec_fx.sv
// AXI4-Stream fixed-point matrix-vector engine: runtime-loaded weights, one MAC per cycle,
// floor-shifted and saturated results streamed row by row.
module axis_matvec_fx #(
  parameter int unsigned N_IN   = 20,
  parameter int unsigned N_OUT  = 10,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned ACC_W  = 2*DATA_W + $clog2(N_IN)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] INPUT_AXIS_TDATA,
  input  logic              INPUT_AXIS_TUSER,
  input  logic              INPUT_AXIS_TLAST,
  input  logic              INPUT_AXIS_TVALID,
  output logic              INPUT_AXIS_TREADY,
  output logic [DATA_W-1:0] OUTPUT_AXIS_TDATA,
  output logic              OUTPUT_AXIS_TLAST,
  output logic              OUTPUT_AXIS_TVALID,
  input  logic              OUTPUT_AXIS_TREADY,
  output logic              FRAME_ERR
);

  localparam int unsigned N_W   = N_IN * N_OUT;
  localparam int unsigned CNT_W = $clog2(N_W + 1);
  localparam int unsigned COL_W = $clog2(N_IN + 1);
  localparam int unsigned ROW_W = $clog2(N_OUT + 1);
  localparam int unsigned WA_W  = $clog2(N_W);
  localparam int unsigned XA_W  = $clog2(N_IN);
  localparam int unsigned P_W   = 2 * DATA_W;

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, COMPUTE, SEND} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] w_mem [N_W];
  logic signed [DATA_W-1:0] x_mem [N_IN];
  logic [CNT_W-1:0]         idx;
  logic [CNT_W-1:0]         wptr;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic signed [ACC_W-1:0]  acc;

  logic                     beat_c;
  logic                     is_w_c;
  logic [CNT_W-1:0]         cur_c;
  logic [CNT_W-1:0]         exp_c;
  logic signed [DATA_W-1:0] wv_c;
  logic signed [DATA_W-1:0] xv_c;
  logic signed [P_W-1:0]    prod_c;
  logic signed [ACC_W-1:0]  shr_c;
  logic [ACC_W-DATA_W:0]    hi_c;
  logic [DATA_W-1:0]        y_sat_c;

  // Frame bookkeeping, MAC operands and the floor/saturate of the finished row.
  always_comb begin
    beat_c  = INPUT_AXIS_TVALID && INPUT_AXIS_TREADY;
    is_w_c  = (state == IDLE) ? INPUT_AXIS_TUSER : (state == LOAD_W);
    cur_c   = (state == IDLE) ? '0 : idx;
    exp_c   = is_w_c ? CNT_W'(N_W) : CNT_W'(N_IN);
    wv_c    = w_mem[wptr[WA_W-1:0]];
    xv_c    = x_mem[col[XA_W-1:0]];
    prod_c  = P_W'(wv_c) * P_W'(xv_c);
    shr_c   = acc >>> FRAC_W;
    hi_c    = shr_c[ACC_W-1:DATA_W-1];
    y_sat_c = shr_c[DATA_W-1:0];
    if (!((&hi_c) || !(|hi_c))) begin
      y_sat_c = shr_c[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state              <= IDLE;
      idx                <= '0;
      wptr               <= '0;
      col                <= '0;
      row                <= '0;
      acc                <= '0;
      INPUT_AXIS_TREADY  <= 1'b0;
      OUTPUT_AXIS_TDATA  <= '0;
      OUTPUT_AXIS_TLAST  <= 1'b0;
      OUTPUT_AXIS_TVALID <= 1'b0;
      FRAME_ERR          <= 1'b0;
      for (int unsigned k = 0; k < N_W; k++) w_mem[WA_W'(k)] <= '0;
      for (int unsigned k = 0; k < N_IN; k++) x_mem[XA_W'(k)] <= '0;
    end else begin
      case (state)
        IDLE, LOAD_W, LOAD_X: begin
          INPUT_AXIS_TREADY <= 1'b1;
          if (beat_c) begin
            state <= is_w_c ? LOAD_W : LOAD_X;
            // Index saturates at the expected length so long frames only discard.
            if (cur_c < exp_c) begin
              idx <= cur_c + CNT_W'(1);
              if (is_w_c) w_mem[cur_c[WA_W-1:0]] <= INPUT_AXIS_TDATA;
              else        x_mem[cur_c[XA_W-1:0]] <= INPUT_AXIS_TDATA;
            end else begin
              idx <= cur_c;
            end
            if (INPUT_AXIS_TLAST) begin
              idx <= '0;
              if (cur_c + CNT_W'(1) != exp_c) FRAME_ERR <= 1'b1;
              for (int unsigned k = 0; k < N_W; k++)
                if (is_w_c && CNT_W'(k) > cur_c) w_mem[WA_W'(k)] <= '0;
              for (int unsigned k = 0; k < N_IN; k++)
                if (!is_w_c && CNT_W'(k) > cur_c) x_mem[XA_W'(k)] <= '0;
              if (is_w_c) begin
                state <= IDLE;
              end else begin
                state             <= COMPUTE;
                INPUT_AXIS_TREADY <= 1'b0;
                col               <= '0;
                row               <= '0;
                wptr              <= '0;
                acc               <= '0;
              end
            end
          end
        end
        COMPUTE: begin
          // N_IN MAC cycles, then one cycle to register the saturated result.
          if (col < COL_W'(N_IN)) begin
            acc  <= acc + ACC_W'(prod_c);
            col  <= col + COL_W'(1);
            wptr <= wptr + CNT_W'(1);
          end else begin
            OUTPUT_AXIS_TDATA  <= y_sat_c;
            OUTPUT_AXIS_TLAST  <= (row == ROW_W'(N_OUT - 1));
            OUTPUT_AXIS_TVALID <= 1'b1;
            state              <= SEND;
          end
        end
        SEND: begin
          if (OUTPUT_AXIS_TREADY) begin
            OUTPUT_AXIS_TVALID <= 1'b0;
            OUTPUT_AXIS_TLAST  <= 1'b0;
            if (row == ROW_W'(N_OUT - 1)) begin
              state             <= IDLE;
              INPUT_AXIS_TREADY <= 1'b1;
            end else begin
              row   <= row + ROW_W'(1);
              col   <= '0;
              acc   <= '0;
              state <= COMPUTE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_matvec_fx.sv
// Bench for axis_matvec_fx: directed and random frames checked against an arithmetic
// matrix-vector reference with floor and saturation.
module tb_axis_matvec_fx;

  localparam int N_IN   = 20;
  localparam int N_OUT  = 10;
  localparam int FRAC_W = 8;
  localparam int N_W    = N_IN * N_OUT;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] INPUT_AXIS_TDATA = '0;
  logic        INPUT_AXIS_TUSER = 1'b0;
  logic        INPUT_AXIS_TLAST = 1'b0;
  logic        INPUT_AXIS_TVALID = 1'b0;
  logic        INPUT_AXIS_TREADY;
  logic [15:0] OUTPUT_AXIS_TDATA;
  logic        OUTPUT_AXIS_TLAST;
  logic        OUTPUT_AXIS_TVALID;
  logic        OUTPUT_AXIS_TREADY = 1'b0;
  logic        FRAME_ERR;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;

  logic [15:0] fw [N_W + 8];
  logic [15:0] fx [N_IN + 8];
  logic [15:0] wm [N_W];
  logic [15:0] xm [N_IN];
  logic        err_m = 1'b0;

  axis_matvec_fx dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .INPUT_AXIS_TDATA   (INPUT_AXIS_TDATA),
    .INPUT_AXIS_TUSER   (INPUT_AXIS_TUSER),
    .INPUT_AXIS_TLAST   (INPUT_AXIS_TLAST),
    .INPUT_AXIS_TVALID  (INPUT_AXIS_TVALID),
    .INPUT_AXIS_TREADY  (INPUT_AXIS_TREADY),
    .OUTPUT_AXIS_TDATA  (OUTPUT_AXIS_TDATA),
    .OUTPUT_AXIS_TLAST  (OUTPUT_AXIS_TLAST),
    .OUTPUT_AXIS_TVALID (OUTPUT_AXIS_TVALID),
    .OUTPUT_AXIS_TREADY (OUTPUT_AXIS_TREADY),
    .FRAME_ERR          (FRAME_ERR)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // y[r] = floor(sum W[r][c]*x[c] / 2^FRAC_W), clamped to the signed 16-bit range.
  function automatic logic [15:0] ref_y(input int r);
    longint acc = 0;
    for (int c = 0; c < N_IN; c++)
      acc += longint'($signed(wm[r*N_IN + c])) * longint'($signed(xm[c]));
    acc = acc >>> FRAC_W;
    if (acc > 32767) return 16'h7FFF;
    if (acc < -32768) return 16'h8000;
    return acc[15:0];
  endfunction

  task automatic push(input logic [15:0] d, input logic u, input logic l);
    int t = 0;
    @(negedge aclk);
    INPUT_AXIS_TDATA  = d;
    INPUT_AXIS_TUSER  = u;
    INPUT_AXIS_TLAST  = l;
    INPUT_AXIS_TVALID = 1'b1;
    while (INPUT_AXIS_TREADY !== 1'b1 && t < 200) begin
      @(negedge aclk);
      t++;
    end
    chk("in_ready", 32'(INPUT_AXIS_TREADY), 32'd1);
    @(posedge aclk);
    #1;
    INPUT_AXIS_TVALID = 1'b0;
    last_cyc = cyc;
  endtask

  // Sends n beats from fw (weights) or fx (vector) and updates the reference state.
  task automatic send_frame(input bit is_w, input int n);
    int expn = is_w ? N_W : N_IN;
    for (int k = 0; k < n; k++)
      push(is_w ? fw[k] : fx[k], (k == 0) ? is_w : 1'($urandom_range(0, 1)), k == n - 1);
    for (int k = 0; k < expn; k++) begin
      if (is_w) wm[k] = (k < n) ? fw[k] : 16'h0000;
      else      xm[k] = (k < n) ? fx[k] : 16'h0000;
    end
    if (n != expn) err_m = 1'b1;
  endtask

  // bp_mode: 0 always ready, 1 toggling, 2 random.
  task automatic get_outputs(input int nrows, input int bp_mode);
    int r = 0;
    int t = 0;
    int due = last_cyc + N_IN + 1;
    bit held = 0;
    bit seen = 0;
    logic [15:0] hd = '0;
    logic hl = 1'b0;
    OUTPUT_AXIS_TREADY = (bp_mode == 0);
    while (r < nrows && t < 3000) begin
      @(negedge aclk);
      t++;
      chk("in_ready_low", 32'(INPUT_AXIS_TREADY), 32'd0);
      if (OUTPUT_AXIS_TVALID === 1'b1) begin
        if (!seen) begin
          chk($sformatf("latency_row%0d", r), 32'(cyc), 32'(due));
          seen = 1;
        end
        if (held) begin
          chk("hold_data", 32'(OUTPUT_AXIS_TDATA), 32'(hd));
          chk("hold_last", 32'(OUTPUT_AXIS_TLAST), 32'(hl));
        end
        if (OUTPUT_AXIS_TREADY) begin
          chk($sformatf("y%0d", r), 32'(OUTPUT_AXIS_TDATA), 32'(ref_y(r)));
          chk($sformatf("tlast%0d", r), 32'(OUTPUT_AXIS_TLAST), 32'(r == N_OUT - 1));
          r++;
          held = 0;
          seen = 0;
          due  = cyc + 1 + N_IN + 1;
        end else begin
          held = 1;
          hd   = OUTPUT_AXIS_TDATA;
          hl   = OUTPUT_AXIS_TLAST;
        end
      end
      @(posedge aclk);
      #1;
      case (bp_mode)
        1:       OUTPUT_AXIS_TREADY = ~OUTPUT_AXIS_TREADY;
        2:       OUTPUT_AXIS_TREADY = 1'($urandom_range(0, 1));
        default: OUTPUT_AXIS_TREADY = 1'b1;
      endcase
    end
    chk("out_rows", 32'(r), 32'(nrows));
  endtask

  task automatic after_frame(input string tag);
    @(negedge aclk);
    chk({tag, "_valid_drop"}, 32'(OUTPUT_AXIS_TVALID), 32'd0);
    chk({tag, "_in_ready"}, 32'(INPUT_AXIS_TREADY), 32'd1);
    chk({tag, "_frame_err"}, 32'(FRAME_ERR), 32'(err_m));
  endtask

  task automatic run_vector(input string tag, input int bp_mode);
    send_frame(0, N_IN);
    get_outputs(N_OUT, bp_mode);
    after_frame(tag);
  endtask

  task automatic set_identity();
    for (int k = 0; k < N_W; k++) fw[k] = ((k / N_IN) == (k % N_IN)) ? 16'h0100 : 16'h0000;
  endtask

  task automatic set_ramp();
    for (int c = 0; c < N_IN; c++) fx[c] = 16'(c << 8);
  endtask

  initial begin
    for (int k = 0; k < N_W; k++) wm[k] = '0;
    for (int k = 0; k < N_IN; k++) xm[k] = '0;

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_in_ready", 32'(INPUT_AXIS_TREADY), 32'd0);
    chk("rst_valid", 32'(OUTPUT_AXIS_TVALID), 32'd0);
    chk("rst_last", 32'(OUTPUT_AXIS_TLAST), 32'd0);
    chk("rst_data", 32'(OUTPUT_AXIS_TDATA), 32'd0);
    chk("rst_frame_err", 32'(FRAME_ERR), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_in_ready", 32'(INPUT_AXIS_TREADY), 32'd1);

    // Identity weights, ramp vector; then the same under toggling backpressure
    set_identity();
    send_frame(1, N_W);
    set_ramp();
    run_vector("identity", 0);
    run_vector("identity_bp", 1);

    // Saturation both ways
    for (int k = 0; k < N_W; k++) fw[k] = 16'h7FFF;
    send_frame(1, N_W);
    for (int c = 0; c < N_IN; c++) fx[c] = 16'h7FFF;
    run_vector("sat_pos", 0);
    for (int c = 0; c < N_IN; c++) fx[c] = 16'h8000;
    run_vector("sat_neg", 2);

    // Floor of a negative fraction
    for (int k = 0; k < N_W; k++) fw[k] = 16'h0000;
    fw[0] = 16'hFF00;
    send_frame(1, N_W);
    for (int c = 0; c < N_IN; c++) fx[c] = 16'h0000;
    fx[0] = 16'h0001;
    run_vector("floor", 0);

    // Random weights and vectors, full range and small magnitudes
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < N_W; k++)
        fw[k] = (s == 0) ? 16'($urandom) : 16'($signed(12'($urandom)));
      send_frame(1, N_W);
      for (int v = 0; v < 3; v++) begin
        for (int c = 0; c < N_IN; c++)
          fx[c] = (v == 0) ? 16'($urandom) : 16'($signed(12'($urandom)));
        run_vector("random", 2);
      end
    end

    // Frame errors: short vector, long vector, short weight frame
    set_identity();
    send_frame(1, N_W);
    set_ramp();
    send_frame(0, 5);
    get_outputs(N_OUT, 0);
    after_frame("short_vec");
    for (int c = 0; c < N_IN + 3; c++) fx[c] = 16'($signed(12'($urandom)));
    send_frame(0, N_IN + 3);
    get_outputs(N_OUT, 2);
    after_frame("long_vec");
    for (int k = 0; k < N_W; k++) fw[k] = 16'($signed(12'($urandom)));
    send_frame(1, 150);
    chk("short_w_frame_err", 32'(FRAME_ERR), 32'(err_m));
    for (int c = 0; c < N_IN; c++) fx[c] = 16'($signed(12'($urandom)));
    run_vector("short_w", 1);

    // Reset while a result is pending, then weights must read back as zero
    set_identity();
    send_frame(1, N_W);
    set_ramp();
    send_frame(0, N_IN);
    get_outputs(3, 0);
    OUTPUT_AXIS_TREADY = 1'b0;
    for (int t = 0; t < 100 && OUTPUT_AXIS_TVALID !== 1'b1; t++) @(negedge aclk);
    chk("pending_valid", 32'(OUTPUT_AXIS_TVALID), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("midrst_valid", 32'(OUTPUT_AXIS_TVALID), 32'd0);
    chk("midrst_in_ready", 32'(INPUT_AXIS_TREADY), 32'd0);
    chk("midrst_data", 32'(OUTPUT_AXIS_TDATA), 32'd0);
    chk("midrst_frame_err", 32'(FRAME_ERR), 32'd0);
    for (int k = 0; k < N_W; k++) wm[k] = '0;
    for (int k = 0; k < N_IN; k++) xm[k] = '0;
    err_m = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rerst_in_ready", 32'(INPUT_AXIS_TREADY), 32'd1);
    set_ramp();
    run_vector("after_reset", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
